lifo_reader: RTL and testbench
==============================

LIFO_READER -- requirements
Module: lifo_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width.
REQ-002 SHALL have parameter AWIDTH_EXP, default 3; LIFO depth is 2**AWIDTH_EXP.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port srst_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port drain_i  input  1  one-cycle request to start a drain burst.
REQ-006 SHALL have port empty_i  input  1  LIFO empty flag.
REQ-007 SHALL have port full_i  input  1  LIFO full flag.
REQ-008 SHALL have port q_i  input  DWIDTH  LIFO read data, valid one cycle after rdreq_o.
REQ-009 SHALL have port rdreq_o  output  1  LIFO pop request.
REQ-010 SHALL have port data_o  output  DWIDTH  stream data.
REQ-011 SHALL have port valid_o  output  1  stream valid.
REQ-012 SHALL have port ready_i  input  1  stream ready.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse at burst end.
REQ-015 SHALL have port count_o  output  AWIDTH_EXP+1  words popped in the current or last burst.

Function
REQ-016 SHALL implement FSM states IDLE, DRAIN, FLUSH.
REQ-017 SHALL move IDLE->DRAIN on drain_i=1; drain_i outside IDLE is ignored.
REQ-018 SHALL clear count_o to 0 on the IDLE->DRAIN transition.
REQ-019 SHALL drive rdreq_o = (state==DRAIN) & !empty_i & (buffer occupancy + in-flight reads < 2), combinationally.
REQ-020 SHALL capture q_i into a 2-entry output buffer exactly one cycle after each rdreq_o, preserving pop order (newest LIFO entry first).
REQ-021 SHALL increment count_o by 1 on every cycle rdreq_o=1; count_o never exceeds 2**AWIDTH_EXP.
REQ-022 SHALL assert valid_o whenever the buffer is non-empty, with data_o the oldest buffered word.
REQ-023 SHALL hold data_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL transfer one word per cycle with valid_o=1 and ready_i=1; sustained throughput is 1 word/cycle with ready_i held high.
REQ-025 SHALL move DRAIN->FLUSH when empty_i=1 and no read is in flight.
REQ-026 SHALL move FLUSH->IDLE when the buffer is empty, pulsing done_o=1 for that one cycle.
REQ-027 SHALL permit buffer fill and drain in the same cycle, with occupancy unchanged.
REQ-028 SHALL treat full_i=1 with empty_i=0 as a normal non-empty LIFO; usedw is not required.

Reset
REQ-029 SHALL, when srst_i=0 at a clock edge, enter IDLE and clear the buffer, the in-flight flag, count_o and done_o.
REQ-030 SHALL hold rdreq_o=0, valid_o=0, busy_o=0 and data_o=0 while srst_i=0.
REQ-031 SHALL discard all buffered and in-flight data on reset mid-burst; the next burst starts clean.

Configuration
REQ-032 SHALL, with LIFO_READER_AUTO_DRAIN_EN defined, also move IDLE->DRAIN when full_i=1.
REQ-033 SHALL, without LIFO_READER_AUTO_DRAIN_EN, start a drain only on drain_i.

Structure
REQ-034 SHALL place the FSM state enum type and the buffer depth constant (2) in shared package lifo_pkg.
REQ-035 SHALL implement the 2-entry output buffer as sub-module lifo_reader_skid; the FSM and counter stay in lifo_reader.

Verification
REQ-036 Bench: LIFO holds 3, 7, 9 (9 pushed last), ready_i=1, drain_i pulse -> data_o 9, 7, 3 on consecutive cycles; count_o=3; done_o pulses once.
REQ-037 Bench: full LIFO (8 words), ready_i held 0 for 10 cycles after drain_i -> at most 2 rdreq_o pulses, data_o stable; on release, all 8 words drain in LIFO order; count_o=8.
REQ-038 Bench: drain_i with empty LIFO -> no rdreq_o; DRAIN->FLUSH->IDLE; done_o pulses within 3 cycles; count_o=0.
REQ-039 Bench: srst_i=0 after 2 words popped -> next cycle valid_o=0, busy_o=0, count_o=0; a new burst drains the remaining words correctly.
REQ-040 Bench: with LIFO_READER_AUTO_DRAIN_EN, fill to 8 words without drain_i -> burst starts on full_i, 8 words delivered; without the macro -> no rdreq_o.
REQ-041 Bench: ready_i toggled randomly over 64 words across 8 bursts -> output matches a LIFO reference model; no word lost or duplicated.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared types and constants for the LIFO drain reader.
package lifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } lifo_state_e;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/lifo_reader_if.sv
// Valid/ready word stream leaving the LIFO reader.
interface lifo_reader_if #(
  parameter int DWIDTH = 8
);
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/lifo_reader_skid.sv
// Two-entry in-order output buffer: catches LIFO read data and presents it
// on the valid/ready stream, head entry first.
module lifo_reader_skid
  import lifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  output logic [1:0]        occ_o,
  lifo_reader_if.master     out_if
);

  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop;

  assign pop = (occ_q != 2'd0) & out_if.ready;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous fill and drain: occupancy stays, queue shifts by one.
        if (occ_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      // NOTE: the data entries are reset too, because data_o must read 0 after reset.
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o        = occ_q;
  assign out_if.valid = srst_i & (occ_q != 2'd0);
  assign out_if.data  = srst_i ? head_q : '0;

endmodule

// File: rtl/lifo_reader.sv
// Drains a LIFO into a valid/ready stream on request.
// Define LIFO_READER_AUTO_DRAIN_EN to also start a burst whenever the LIFO is full.
module lifo_reader
  import lifo_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH_EXP = 3
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic                drain_i,
  input  logic                empty_i,
  input  logic                full_i,
  input  logic [DWIDTH-1:0]   q_i,
  output logic                rdreq_o,
  output logic [DWIDTH-1:0]   data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [AWIDTH_EXP:0] count_o
);

  localparam int CW = AWIDTH_EXP + 1;
  localparam logic [CW-1:0] MAX_COUNT = CW'(1) << AWIDTH_EXP;

  lifo_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q;
  logic          done_q, done_d;
  logic [1:0]    occ;
  logic [1:0]    load;
  logic          pop;
  logic          start;

  lifo_reader_if #(.DWIDTH(DWIDTH)) stream ();

  assign stream.ready = ready_i;
  assign valid_o      = stream.valid;
  assign data_o       = stream.data;

  lifo_reader_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .push_i      (inflight_q),
    .push_data_i (q_i),
    .occ_o       (occ),
    .out_if      (stream)
  );

`ifdef LIFO_READER_AUTO_DRAIN_EN
  assign start = drain_i | full_i;
`else
  logic unused_full;
  assign unused_full = full_i;
  assign start       = drain_i;
`endif

  // The word leaving this cycle frees its slot, so a pop can be re-issued in
  // the same cycle; this is what sustains one word per cycle with ready held high.
  assign pop     = stream.valid & ready_i;
  assign load    = occ + {1'b0, inflight_q} - {1'b0, pop};
  assign rdreq_o = srst_i & (state_q == ST_DRAIN) & ~empty_i & (load < 2'(BUF_DEPTH));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRAIN;
          count_d = '0;
        end
      end
      ST_DRAIN: begin
        if (empty_i && !inflight_q) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (occ == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rdreq_o && (count_q != MAX_COUNT)) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= rdreq_o;
      done_q     <= done_d;
    end
  end

  assign busy_o  = srst_i & (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_lifo_reader.sv
// Randomized bench for lifo_reader: an array-backed LIFO feeds the DUT and each
// burst is scored against the LIFO contents read top-first.
module tb_lifo_reader;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk     = 1'b0;
  logic          srst_i  = 1'b0;
  logic          drain_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] q_i     = '0;
  logic          empty_i, full_i;
  logic          rdreq_o, valid_o, busy_o, done_o;
  logic [DW-1:0] data_o;
  logic [AW:0]   count_o;

  logic          push_req  = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] mem [DEPTH];
  int            sp = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lifo_reader_if #(.DWIDTH(DW)) mon_if ();
  assign mon_if.valid = valid_o;
  assign mon_if.data  = data_o;
  assign mon_if.ready = ready_i;

  lifo_reader #(.DWIDTH(DW), .AWIDTH_EXP(AW)) dut (
    .clk_i   (clk),
    .srst_i  (srst_i),
    .drain_i (drain_i),
    .empty_i (empty_i),
    .full_i  (full_i),
    .q_i     (q_i),
    .rdreq_o (rdreq_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .count_o (count_o)
  );

  // Behavioural LIFO: pop returns the top word one cycle after the request.
  assign empty_i = (sp == 0);
  assign full_i  = (sp == DEPTH);

  always @(posedge clk) begin
    if (rdreq_o && sp > 0) begin
      q_i <= mem[sp-1];
      sp  <= sp - 1;
    end else if (push_req && sp < DEPTH) begin
      mem[sp] <= push_data;
      sp      <= sp + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    push_req  = 1'b1;
    push_data = v;
    @(negedge clk);
    push_req  = 1'b0;
  endtask

  // Entered at a negedge; drives one burst and scores it against the LIFO snapshot.
  task automatic run_burst(input int ready_pct, input bit use_drain, input int hold_low,
                           output int hold_rdreq, output int done_cycle);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] want;
    bit            prev_stall = 1'b0;
    bit            seen_done  = 1'b0;
    int            first = -1, last = -1, n, xfers = 0;
    for (int i = sp - 1; i >= 0; i--) exp_q.push_back(mem[i]);
    n          = exp_q.size();
    hold_rdreq = 0;
    done_cycle = -1;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      drain_i = use_drain && (cyc == 0);
      ready_i = (cyc < hold_low) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      #1;
      if (rdreq_o && cyc < hold_low) hold_rdreq++;
      if (prev_stall) begin
        check("hold_valid", 32'(valid_o), 32'd1);
        check("hold_data", 32'(data_o), 32'(prev_data));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("data", 32'(mon_if.data), 32'(want));
        end
        xfers++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      if (done_o) begin
        seen_done  = 1'b1;
        done_cycle = cyc;
      end
    end
    drain_i = 1'b0;
    check("done_seen", 32'(seen_done), 32'd1);
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("xfers", 32'(xfers), 32'(n));
    check("count", 32'(count_o), 32'(n));
    if (ready_pct == 100 && hold_low == 0 && n > 1)
      check("back_to_back", 32'(last - first), 32'(n - 1));
    @(negedge clk);
    check("done_single", 32'(done_o), 32'd0);
    check("busy_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int hold_rdreq, done_cycle, pulses;

    // Reset state
    srst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdreq", 32'(rdreq_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_data",  32'(data_o),  32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_done",  32'(done_o),  32'd0);
    srst_i = 1'b1;
    @(negedge clk);

    // 3, 7, 9 with ready high: 9, 7, 3 back to back
    push_word(8'd3);
    push_word(8'd7);
    push_word(8'd9);
    run_burst(100, 1'b1, 0, hold_rdreq, done_cycle);

    // Drain request on an empty LIFO
    run_burst(100, 1'b1, 0, hold_rdreq, done_cycle);
    check("empty_rdreq", 32'(hold_rdreq), 32'd0);
    check("empty_done_lat", 32'(done_cycle <= 3), 32'd1);

    // Full LIFO, ready held low for 10 cycles
    for (int i = 0; i < DEPTH; i++) push_word(DW'($urandom));
`ifdef LIFO_READER_AUTO_DRAIN_EN
    run_burst(100, 1'b0, 10, hold_rdreq, done_cycle);
`else
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (rdreq_o || busy_o) pulses++;
    end
    check("no_auto_drain", 32'(pulses), 32'd0);
    run_burst(100, 1'b1, 10, hold_rdreq, done_cycle);
`endif
    check("hold_rdreq_max2", 32'(hold_rdreq <= 2), 32'd1);

    // Reset after two words popped; the remaining words drain in a new burst
    for (int i = 0; i < 5; i++) push_word(DW'($urandom));
    drain_i = 1'b1;
    ready_i = 1'b0;
    pulses  = 0;
    for (int c = 0; c < 10 && pulses < 2; c++) begin
      @(negedge clk);
      drain_i = 1'b0;
      #1;
      if (rdreq_o) pulses++;
    end
    check("pre_rst_pops", 32'(pulses), 32'd2);
    @(negedge clk);
    srst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_busy",  32'(busy_o),  32'd0);
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_rdreq", 32'(rdreq_o), 32'd0);
    srst_i = 1'b1;
    @(negedge clk);
    run_burst(100, 1'b1, 0, hold_rdreq, done_cycle);

    // 64 words over 8 bursts with random backpressure
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < DEPTH; i++) push_word(DW'($urandom));
      run_burst(50, 1'b1, 0, hold_rdreq, done_cycle);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
